// File: rtl/dsp_seq_pkg.sv
// Shared types and default widths for the multi-shot DSP run sequencer.
package dsp_seq_pkg;

   localparam int DEF_NPROC    = 4;
   localparam int DEF_CNTWIDTH = 32;
   localparam int DEF_GAPWIDTH = 16;
   localparam int DEF_TOWIDTH  = 27;
   localparam int DEF_RSTLEN   = 2;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RST  = 3'd1,
      S_RUN  = 3'd2,
      S_GAP  = 3'd3,
      S_DONE = 3'd4
   } seq_state_t;

endpackage

// File: rtl/seq_downcnt.sv
// Loadable down-counter with zero flag; load wins over decrement and the count
// saturates at zero.
module seq_downcnt #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] count_r;

   // counter register
   always_ff @(posedge clk) begin
      if (reset) begin
         count_r <= '0;
      end else if (load) begin
         count_r <= load_val;
      end else if (dec && (count_r != '0)) begin
         count_r <= count_r - W'(1);
      end else begin
         count_r <= count_r;
      end
   end

   assign zero = (count_r == '0);

endmodule

// File: rtl/shot_sequencer.sv
// Multi-shot run controller: per shot it pulses the core resets, waits for every
// core's end-of-program, then inserts an inter-shot gap before the next shot.
module shot_sequencer
   import dsp_seq_pkg::*;
#(
   parameter int NPROC    = DEF_NPROC,
   parameter int CNTWIDTH = DEF_CNTWIDTH,
   parameter int GAPWIDTH = DEF_GAPWIDTH,
   parameter int TOWIDTH  = DEF_TOWIDTH,
   parameter int RSTLEN   = DEF_RSTLEN
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                stb_start,
   input  logic [CNTWIDTH-1:0] nshot,
   input  logic [GAPWIDTH-1:0] gap,
   input  logic [TOWIDTH-1:0]  timeout,
   input  logic                abort,
   input  logic [NPROC-1:0]    stbprocend,
   output logic [NPROC-1:0]    proccorereset,
   output logic                shotbusy,
   output logic [CNTWIDTH-1:0] shotcnt,
   output logic                stb_shotstart,
   output logic                lastshotdone,
   output logic [NPROC-1:0]    procdone,
   output logic                timedout
);

   localparam int RW = (RSTLEN > 1) ? $clog2(RSTLEN) : 1;

   seq_state_t          state_r, next_s;
   logic [CNTWIDTH-1:0] nshot_r, shotcnt_r;
   logic [GAPWIDTH-1:0] gap_r;
   logic [TOWIDTH-1:0]  timeout_r;
   logic [NPROC-1:0]    procdone_r, proccorereset_r;
   logic                shotbusy_r, stb_shotstart_r, lastshotdone_r, timedout_r;

   logic                start_acc_s, complete_s, last_s, tmo_s, incr_s;
   logic                enter_rst_s, enter_gap_s, enter_run_s;
   logic                rst_zero_s, gap_zero_s, to_zero_s;

   // shot event decode
   always_comb begin
      start_acc_s = (state_r == S_IDLE) && stb_start && !abort;
      complete_s  = (state_r == S_RUN) && (&(procdone_r | stbprocend));
      last_s      = (shotcnt_r == (nshot_r - CNTWIDTH'(1)));
      tmo_s       = (state_r == S_RUN) && !complete_s && (timeout_r != '0) && to_zero_s;
      incr_s      = complete_s && !last_s && !abort;
   end

   // next-state logic; abort overrides every transition
   always_comb begin
      next_s = state_r;
      if (abort) begin
         next_s = S_IDLE;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (stb_start) begin
                  next_s = (nshot == '0) ? S_DONE : S_RST;
               end else begin
                  next_s = S_IDLE;
               end
            end
            S_RST: begin
               if (rst_zero_s) next_s = S_RUN;
               else            next_s = S_RST;
            end
            S_RUN: begin
               if (complete_s) begin
                  if (last_s)              next_s = S_DONE;
                  else if (gap_r != '0)    next_s = S_GAP;
                  else                     next_s = S_RST;
               end else if (tmo_s) begin
                  next_s = S_IDLE;
               end else begin
                  next_s = S_RUN;
               end
            end
            S_GAP: begin
               if (gap_zero_s) next_s = S_RST;
               else            next_s = S_GAP;
            end
            S_DONE:  next_s = S_IDLE;
            default: next_s = S_IDLE;
         endcase
      end
   end

   // phase entry strobes used to load the counters
   always_comb begin
      enter_rst_s = (next_s == S_RST) && (state_r != S_RST);
      enter_gap_s = (next_s == S_GAP) && (state_r != S_GAP);
      enter_run_s = (next_s == S_RUN) && (state_r != S_RUN);
   end

   seq_downcnt #(.W(RW)) u_rst_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (enter_rst_s),
      .load_val (RW'(RSTLEN - 1)),
      .dec      (state_r == S_RST),
      .zero     (rst_zero_s)
   );

   seq_downcnt #(.W(GAPWIDTH)) u_gap_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (enter_gap_s),
      .load_val (gap_r - GAPWIDTH'(1)),
      .dec      (state_r == S_GAP),
      .zero     (gap_zero_s)
   );

   // timeout expires on the timeout-th RUN cycle of a shot
   seq_downcnt #(.W(TOWIDTH)) u_to_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (enter_run_s),
      .load_val (timeout_r - TOWIDTH'(1)),
      .dec      (state_r == S_RUN),
      .zero     (to_zero_s)
   );

   // state register and run configuration captured at an accepted start
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= S_IDLE;
         nshot_r   <= '0;
         gap_r     <= '0;
         timeout_r <= '0;
      end else begin
         state_r <= next_s;
         if (start_acc_s) begin
            nshot_r   <= nshot;
            gap_r     <= gap;
            timeout_r <= timeout;
         end
      end
   end

   // shot index, sticky per-core done flags and timeout flag
   always_ff @(posedge clk) begin
      if (reset) begin
         shotcnt_r  <= '0;
         procdone_r <= '0;
         timedout_r <= 1'b0;
      end else begin
         if (start_acc_s)  shotcnt_r <= '0;
         else if (incr_s)  shotcnt_r <= shotcnt_r + CNTWIDTH'(1);

         if (start_acc_s || enter_rst_s) procdone_r <= '0;
         else if (state_r == S_RUN)      procdone_r <= procdone_r | stbprocend;

         if (start_acc_s)              timedout_r <= 1'b0;
         else if (tmo_s && !abort)     timedout_r <= 1'b1;
      end
   end

   // outputs registered from the next state so they align with the state register
   always_ff @(posedge clk) begin
      if (reset) begin
         proccorereset_r <= '1;
         shotbusy_r      <= 1'b0;
         stb_shotstart_r <= 1'b0;
         lastshotdone_r  <= 1'b0;
      end else begin
         proccorereset_r <= {NPROC{next_s != S_RUN}};
         shotbusy_r      <= (next_s == S_RST) || (next_s == S_RUN) || (next_s == S_GAP);
         stb_shotstart_r <= enter_run_s;
         lastshotdone_r  <= (next_s == S_DONE);
      end
   end

   assign proccorereset = proccorereset_r;
   assign shotbusy      = shotbusy_r;
   assign shotcnt       = shotcnt_r;
   assign stb_shotstart = stb_shotstart_r;
   assign lastshotdone  = lastshotdone_r;
   assign procdone      = procdone_r;
   assign timedout      = timedout_r;

endmodule

// File: tb/tb_shot_sequencer.sv
// Directed self-checking bench for shot_sequencer (NPROC=4, RSTLEN=2).
module tb_shot_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        stb_start;
   logic [31:0] nshot;
   logic [15:0] gap;
   logic [26:0] timeout;
   logic        abort;
   logic [3:0]  stbprocend;
   logic [3:0]  proccorereset;
   logic        shotbusy;
   logic [31:0] shotcnt;
   logic        stb_shotstart;
   logic        lastshotdone;
   logic [3:0]  procdone;
   logic        timedout;

   int total = 0;
   int bad   = 0;

   shot_sequencer #(
      .NPROC(4), .CNTWIDTH(32), .GAPWIDTH(16), .TOWIDTH(27), .RSTLEN(2)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .stb_start     (stb_start),
      .nshot         (nshot),
      .gap           (gap),
      .timeout       (timeout),
      .abort         (abort),
      .stbprocend    (stbprocend),
      .proccorereset (proccorereset),
      .shotbusy      (shotbusy),
      .shotcnt       (shotcnt),
      .stb_shotstart (stb_shotstart),
      .lastshotdone  (lastshotdone),
      .procdone      (procdone),
      .timedout      (timedout)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic start(input logic [31:0] n, input logic [15:0] g, input logic [26:0] t);
      nshot     = n;
      gap       = g;
      timeout   = t;
      stb_start = 1'b1;
      tick();
      stb_start = 1'b0;
   endtask

   // Called on the first RUN cycle; cores finish on staggered cycles, core 0 strobes twice.
   task automatic run_shot(input logic [31:0] k);
      chk1("shot_start", stb_shotstart, 1'b1);
      chk4("run_core_rst", proccorereset, 4'h0);
      chk32("run_shotcnt", shotcnt, k);
      stbprocend = 4'b0001; tick();
      chk4("pd_0001", procdone, 4'b0001);
      chk1("shot_start_low", stb_shotstart, 1'b0);
      stbprocend = 4'b0001; tick();
      chk4("pd_repeat", procdone, 4'b0001);
      stbprocend = 4'b0010; tick();
      chk4("pd_0011", procdone, 4'b0011);
      stbprocend = 4'b0100; tick();
      chk4("pd_0111", procdone, 4'b0111);
      chk4("run_core_rst2", proccorereset, 4'h0);
      stbprocend = 4'b1000; tick();
      stbprocend = 4'b0000;
   endtask

   initial begin
      reset = 1'b1; stb_start = 1'b0; nshot = '0; gap = '0; timeout = '0;
      abort = 1'b0; stbprocend = 4'h0;
      tick(); tick();
      chk4("rst_core_rst", proccorereset, 4'hf);
      chk1("rst_busy", shotbusy, 1'b0);
      chk32("rst_shotcnt", shotcnt, 32'd0);
      chk1("rst_shotstart", stb_shotstart, 1'b0);
      chk1("rst_last", lastshotdone, 1'b0);
      chk4("rst_procdone", procdone, 4'h0);
      chk1("rst_timedout", timedout, 1'b0);
      reset = 1'b0;
      tick();

      // three shots, no gap
      start(32'd3, 16'd0, 27'd0);
      chk1("t1_busy", shotbusy, 1'b1);
      chk4("t1_rst1", proccorereset, 4'hf);
      tick();
      chk4("t1_rst2", proccorereset, 4'hf);
      chk1("t1_noss", stb_shotstart, 1'b0);
      tick();
      run_shot(32'd0);
      chk32("t1_cnt1", shotcnt, 32'd1);
      chk4("t1_pd_clr", procdone, 4'h0);
      chk4("t1_rst_b", proccorereset, 4'hf);
      chk1("t1_busy_b", shotbusy, 1'b1);
      tick(); tick();
      run_shot(32'd1);
      chk32("t1_cnt2", shotcnt, 32'd2);
      tick(); tick();
      run_shot(32'd2);
      chk1("t1_last", lastshotdone, 1'b1);
      chk1("t1_busy_done", shotbusy, 1'b0);
      chk32("t1_cnt_done", shotcnt, 32'd2);
      chk4("t1_pd_done", procdone, 4'hf);
      chk4("t1_rst_done", proccorereset, 4'hf);
      tick();
      chk1("t1_last_low", lastshotdone, 1'b0);
      chk32("t1_cnt_hold", shotcnt, 32'd2);

      // single shot, all cores in one cycle, gap never used
      start(32'd1, 16'd5, 27'd0);
      chk4("t2_pd_clr", procdone, 4'h0);
      tick(); tick();
      chk1("t2_ss", stb_shotstart, 1'b1);
      stbprocend = 4'hf; tick(); stbprocend = 4'h0;
      chk1("t2_last", lastshotdone, 1'b1);
      chk1("t2_busy", shotbusy, 1'b0);
      chk4("t2_pd", procdone, 4'hf);
      tick();
      chk1("t2_last_low", lastshotdone, 1'b0);

      // two shots with gap=5: 5 GAP + 2 RST cycles before the second shot start
      start(32'd2, 16'd5, 27'd0);
      tick(); tick();
      chk1("t3_ss0", stb_shotstart, 1'b1);
      stbprocend = 4'hf; tick(); stbprocend = 4'h0;
      chk1("t3_gap_busy", shotbusy, 1'b1);
      chk32("t3_gap_cnt", shotcnt, 32'd1);
      chk4("t3_gap_pd", procdone, 4'hf);
      for (int i = 0; i < 7; i++) begin
         chk1("t3_wait_noss", stb_shotstart, 1'b0);
         chk4("t3_wait_rst", proccorereset, 4'hf);
         tick();
      end
      chk1("t3_ss1", stb_shotstart, 1'b1);
      chk4("t3_pd_clr", procdone, 4'h0);
      stbprocend = 4'hf; tick(); stbprocend = 4'h0;
      chk1("t3_last", lastshotdone, 1'b1);
      chk32("t3_cnt", shotcnt, 32'd1);
      tick();

      // zero shots
      start(32'd0, 16'd5, 27'd0);
      chk1("t4_last", lastshotdone, 1'b1);
      chk1("t4_noss", stb_shotstart, 1'b0);
      chk4("t4_rst", proccorereset, 4'hf);
      chk1("t4_busy", shotbusy, 1'b0);
      chk32("t4_cnt", shotcnt, 32'd0);
      tick();
      chk1("t4_last_low", lastshotdone, 1'b0);
      chk4("t4_rst2", proccorereset, 4'hf);

      // timeout=100 with core 3 silent: RUN cycles 3..102, IDLE at 103
      start(32'd2, 16'd0, 27'd100);
      tick(); tick();
      stbprocend = 4'b0111; tick(); stbprocend = 4'h0;
      for (int i = 0; i < 98; i++) tick();
      chk1("t5_not_yet", timedout, 1'b0);
      chk1("t5_busy", shotbusy, 1'b1);
      chk4("t5_run", proccorereset, 4'h0);
      tick();
      chk1("t5_timedout", timedout, 1'b1);
      chk1("t5_idle", shotbusy, 1'b0);
      chk1("t5_nolast", lastshotdone, 1'b0);
      chk4("t5_rst", proccorereset, 4'hf);
      chk4("t5_pd", procdone, 4'b0111);
      tick();
      chk1("t5_nolast2", lastshotdone, 1'b0);
      start(32'd0, 16'd0, 27'd0);
      chk1("t5_clr", timedout, 1'b0);
      chk1("t5_last", lastshotdone, 1'b1);
      tick();

      // abort in shot 1 of 4, with an ignored start while busy
      start(32'd4, 16'd0, 27'd0);
      tick(); tick();
      chk1("t6_ss0", stb_shotstart, 1'b1);
      stbprocend = 4'hf; tick(); stbprocend = 4'h0;
      nshot = 32'd0; stb_start = 1'b1; tick(); stb_start = 1'b0;
      chk1("t6_ign_busy", shotbusy, 1'b1);
      chk1("t6_ign_last", lastshotdone, 1'b0);
      tick();
      chk1("t6_ss1", stb_shotstart, 1'b1);
      chk32("t6_cnt1", shotcnt, 32'd1);
      stbprocend = 4'b0001; tick(); stbprocend = 4'h0;
      chk4("t6_pd", procdone, 4'b0001);
      abort = 1'b1; tick();
      chk1("t6_abort_idle", shotbusy, 1'b0);
      chk32("t6_cnt_hold", shotcnt, 32'd1);
      chk4("t6_abort_rst", proccorereset, 4'hf);
      chk1("t6_nolast", lastshotdone, 1'b0);
      chk4("t6_pd_hold", procdone, 4'b0001);
      nshot = 32'd2; stb_start = 1'b1; tick();
      stb_start = 1'b0; abort = 1'b0;
      chk1("t6_abort_wins", shotbusy, 1'b0);
      chk32("t6_cnt_hold2", shotcnt, 32'd1);
      tick();
      chk1("t6_still_idle", shotbusy, 1'b0);

      // timeout=1 expires on the first RUN cycle; then sync reset clears everything
      start(32'd3, 16'd0, 27'd1);
      tick(); tick();
      chk1("t7_ss", stb_shotstart, 1'b1);
      stbprocend = 4'b0011; tick(); stbprocend = 4'h0;
      chk1("t7_timedout", timedout, 1'b1);
      chk1("t7_idle", shotbusy, 1'b0);
      chk4("t7_pd", procdone, 4'b0011);
      reset = 1'b1; tick();
      chk1("t8_timedout", timedout, 1'b0);
      chk4("t8_pd", procdone, 4'h0);
      chk32("t8_cnt", shotcnt, 32'd0);
      chk4("t8_core_rst", proccorereset, 4'hf);
      chk1("t8_busy", shotbusy, 1'b0);
      chk1("t8_last", lastshotdone, 1'b0);
      chk1("t8_ss", stb_shotstart, 1'b0);
      reset = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
